// File: rtl/key_debounce_if.sv
// Key debounce port bundle: raw active-low keys in, debounced level and event pulses out.
// The master side drives the raw keys; the slave side is the debouncer.
interface key_debounce_if;
    logic [3:0] key_n;
    logic [3:0] key_value;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    modport master (
        output key_n,
        input  key_value,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_n,
        output key_value,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Four independent push-button debouncers with press/release/long-press pulse reporting.
// Each channel has a 2-flop synchronizer, a 4-state filter FSM, a debounce counter and a hold counter.
module key_debounce #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int LONG_CNT     = 50000000
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    key_debounce_if.slave kif
);
    localparam int NUM_KEYS = 4;
    localparam int CNT_W    = $clog2(LONG_CNT);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CNT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_e;

    // Synchronizer carries the inverted key so a reset value of 0 means "not pressed".
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] ks;

    state_e              state_q [NUM_KEYS];
    state_e              state_d [NUM_KEYS];
    logic [CNT_W-1:0]    deb_q   [NUM_KEYS];
    logic [CNT_W-1:0]    deb_d   [NUM_KEYS];
    logic [CNT_W-1:0]    hold_q  [NUM_KEYS];
    logic [CNT_W-1:0]    hold_d  [NUM_KEYS];

    logic [NUM_KEYS-1:0] value_q,   value_d;
    logic [NUM_KEYS-1:0] press_q,   press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q,    long_d;

    assign sync1_d = ~kif.key_n;
    assign sync2_d = sync1_q;
    assign ks      = sync2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            value_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= IDLE;
                deb_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            value_q   <= value_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                deb_q[i]   <= deb_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // NOTE: every comb output gets a default before the case so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            deb_d[i]   = deb_q[i];
            hold_d[i]  = hold_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (ks[i]) begin
                        state_d[i] = PRESS_FILT;
                        deb_d[i]   = '0;
                    end
                end
                PRESS_FILT: begin
                    if (!ks[i]) begin
                        state_d[i] = IDLE;
                        deb_d[i]   = '0;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i] = DOWN;
                        deb_d[i]   = '0;
                        hold_d[i]  = '0;
                    end else begin
                        deb_d[i]   = deb_q[i] + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!ks[i]) begin
                        state_d[i] = REL_FILT;
                        deb_d[i]   = '0;
                    end else if (hold_q[i] != LONG_LAST) begin
                        hold_d[i]  = hold_q[i] + CNT_ONE;
                    end
                end
                REL_FILT: begin
                    // A bounce back to pressed resumes the hold count where it paused.
                    if (ks[i]) begin
                        state_d[i] = DOWN;
                        deb_d[i]   = '0;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i] = IDLE;
                        deb_d[i]   = '0;
                        hold_d[i]  = '0;
                    end else begin
                        deb_d[i]   = deb_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    deb_d[i]   = '0;
                    hold_d[i]  = '0;
                end
            endcase
        end
    end

    // Outputs decode the same transitions so pulses land in the first cycle of the new state.
    always_comb begin
        value_d   = value_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            unique case (state_q[i])
                IDLE: begin
                    value_d[i] = 1'b0;
                end
                PRESS_FILT: begin
                    if (ks[i] && deb_q[i] == DEB_LAST) begin
                        value_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                    end
                end
                DOWN: begin
                    if (ks[i] && hold_q[i] == LONG_PRE) begin
                        long_d[i] = 1'b1;
                    end
                end
                REL_FILT: begin
                    if (!ks[i] && deb_q[i] == DEB_LAST) begin
                        value_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end
                end
                default: begin
                    value_d[i] = 1'b0;
                end
            endcase
        end
    end

    assign kif.key_value   = value_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CNT=10, LONG_CNT=50: stimulus queues
// expected pulse events, a monitor pops and compares whenever any pulse output is high.
module tb_key_debounce;
    logic sys_clk;
    logic sys_rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] value;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CNT(10),
        .LONG_CNT    (50)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .kif      (kif)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [3:0] press, input logic [3:0] rel,
                        input logic [3:0] lng, input logic [3:0] value);
        exp_t e;
        e.at    = at;
        e.press = press;
        e.rel   = rel;
        e.lng   = lng;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Monitor: any pulse output high must match the next queued event exactly.
    initial begin
        forever begin
            @(negedge sys_clk);
            if ((kif.key_press | kif.key_release | kif.key_long) !== 4'b0000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event",
                          {20'd0, kif.key_press, kif.key_release, kif.key_long}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("event_cycle", cyc, mon_e.at);
                    check("key_press",   {28'd0, kif.key_press},   {28'd0, mon_e.press});
                    check("key_release", {28'd0, kif.key_release}, {28'd0, mon_e.rel});
                    check("key_long",    {28'd0, kif.key_long},    {28'd0, mon_e.lng});
                    check("key_value",   {28'd0, kif.key_value},   {28'd0, mon_e.value});
                end
            end
        end
    end

    initial begin
        int c;
        checks    = 0;
        errors    = 0;
        sys_rst_n = 1'b0;
        kif.key_n = 4'b1111;
        idle(2);
        check("rst_value",   {28'd0, kif.key_value},   32'd0);
        check("rst_press",   {28'd0, kif.key_press},   32'd0);
        check("rst_release", {28'd0, kif.key_release}, 32'd0);
        check("rst_long",    {28'd0, kif.key_long},    32'd0);
        sys_rst_n = 1'b1;
        idle(3);

        // Single key press on channel 0, release before the long-press threshold.
        c = cyc;
        kif.key_n = 4'b1110;
        push(c + 13, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        idle(20);
        check("t1_value_held", {28'd0, kif.key_value}, 32'h1);
        c = cyc;
        kif.key_n = 4'b1111;
        push(c + 13, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        idle(20);

        // Short bounces on channel 1 never get accepted.
        for (int k = 0; k < 3; k++) begin
            kif.key_n = 4'b1101;
            idle(5);
            kif.key_n = 4'b1111;
            idle(5);
        end
        idle(10);
        check("t2_value", {28'd0, kif.key_value}, 32'h0);

        // Long hold on channel 2: press, one long pulse, release.
        c = cyc;
        kif.key_n = 4'b1011;
        push(c + 13, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        push(c + 62, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        idle(80);
        check("t3_value_held", {28'd0, kif.key_value}, 32'h4);
        c = cyc;
        kif.key_n = 4'b1111;
        push(c + 13, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        idle(20);
        check("t3_value_rel", {28'd0, kif.key_value}, 32'h0);

        // Release glitch on channel 3: filtered out, and the hold count pauses 5 cycles.
        c = cyc;
        kif.key_n = 4'b0111;
        push(c + 13, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        push(c + 67, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        idle(20);
        kif.key_n = 4'b1111;
        idle(4);
        kif.key_n = 4'b0111;
        idle(2);
        check("t4_value_glitch", {28'd0, kif.key_value}, 32'h8);
        idle(49);
        c = cyc;
        kif.key_n = 4'b1111;
        push(c + 13, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        idle(20);

        // All four keys together.
        c = cyc;
        kif.key_n = 4'b0000;
        push(c + 13, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        idle(20);
        c = cyc;
        kif.key_n = 4'b1111;
        push(c + 13, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        idle(20);

        // Reset during a hold, key still down afterwards: a fresh press follows.
        c = cyc;
        kif.key_n = 4'b1110;
        push(c + 13, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        idle(20);
        check("t6_value_before_rst", {28'd0, kif.key_value}, 32'h1);
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_value", {28'd0, kif.key_value}, 32'h0);
        check("t6_rst_pulses",
              {20'd0, kif.key_press, kif.key_release, kif.key_long}, 32'd0);
        idle(3);
        sys_rst_n = 1'b1;
        c = cyc;
        push(c + 13, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        idle(20);
        c = cyc;
        kif.key_n = 4'b1111;
        push(c + 13, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        idle(20);

        check("sb_empty", sb_q.size(), 32'd0);
        check("final_value", {28'd0, kif.key_value}, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 1000000, SHALL set the stable-input cycles needed to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter LONG_CNT, default 50000000, SHALL set the debounced-hold cycles before a long-press pulse (1 s at 50 MHz); LONG_CNT > DEBOUNCE_CNT.
REQ-003 sys_clk  input  1  system clock, all logic on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_n  input  4  raw push-button inputs, active-low, asynchronous to sys_clk.
REQ-006 key_value  output  4  debounced key level, 1 = pressed.
REQ-007 key_press  output  4  one-cycle pulse per accepted press.
REQ-008 key_release  output  4  one-cycle pulse per accepted release.
REQ-009 key_long  output  4  one-cycle pulse when an accepted press has been held LONG_CNT cycles.

Function
REQ-010 Each of the 4 channels SHALL be fully independent: own synchronizer, FSM, debounce counter, hold counter.
REQ-011 Each key_n bit SHALL pass a 2-flop synchronizer; FSM acts only on the synchronized value (ks, 1 = pressed).
REQ-012 Per-channel FSM states SHALL be IDLE, PRESS_FILT, DOWN, REL_FILT.
REQ-013 IDLE: ks=1 -> PRESS_FILT, debounce counter = 0; else stay.
REQ-014 PRESS_FILT: ks=1 -> counter +1; ks=0 -> IDLE, counter cleared, no output change; counter reaching DEBOUNCE_CNT-1 with ks=1 -> DOWN.
REQ-015 On the PRESS_FILT->DOWN transition, key_value SHALL go 1 and key_press SHALL pulse high for exactly the first cycle key_value is 1.
REQ-016 Press latency: if key_n bit goes low before edge N and stays low, key_press SHALL be high in the cycle after edge N+DEBOUNCE_CNT+2.
REQ-017 DOWN: hold counter SHALL increment each cycle; when it reaches LONG_CNT-1, key_long SHALL pulse one cycle and the counter SHALL saturate (no repeat while held).
REQ-018 DOWN: ks=0 -> REL_FILT, debounce counter = 0; hold counter pauses.
REQ-019 REL_FILT: ks=0 -> counter +1; ks=1 -> back to DOWN, hold counter resumes, no key_press re-pulse; counter reaching DEBOUNCE_CNT-1 with ks=0 -> IDLE.
REQ-020 On REL_FILT->IDLE, key_value SHALL go 0, key_release SHALL pulse one cycle, both counters SHALL clear.
REQ-021 Counters SHALL be wide enough for LONG_CNT (26 bits at defaults) and never wrap.
REQ-022 key_value SHALL stay 1 through REL_FILT until the release is accepted.
REQ-023 key_press, key_release, key_long SHALL be registered outputs; at most one of them high per channel per cycle.
REQ-024 Simultaneous events on different channels SHALL be reported in the same cycle without interaction.

Reset
REQ-025 sys_rst_n low SHALL immediately force all FSMs to IDLE, counters and synchronizer flops to 0, all outputs to 0, including mid-filter or mid-hold.
REQ-026 After reset release, a key already held low SHALL be treated as a new press (full debounce, then key_press).

Verification (DEBOUNCE_CNT=10, LONG_CNT=50)
REQ-027 key_n=4'b1110 held from edge N -> key_press=4'b0001 one cycle after edge N+12, key_value[0]=1 thereafter.
REQ-028 key_n[1] low for 5 cycles, high, repeated 3 times -> key_press, key_value remain 0.
REQ-029 key_n[2] held low 80 cycles then high -> key_press once, key_long once ~50 cycles later, key_release once ~12 cycles after release, key_value[2] back to 0.
REQ-030 While key_value[3]=1, 4-cycle high glitch on key_n[3] -> no key_release, no second key_press, key_value[3] stays 1.
REQ-031 All four keys pressed on same edge -> key_press=4'b1111 in one cycle; later release -> key_release=4'b1111 in one cycle.
REQ-032 sys_rst_n pulsed low during DOWN of key 0 with key held -> outputs 0 at once; after release, key_press[0] re-pulses 12 cycles later.
